// File: rtl/uart_pkg.sv
// Shared UART definitions: default generator widths and the default-width divisor type.
package uart_pkg;

  localparam int unsigned UART_BAUD_W_DEF = 13;
  localparam int unsigned UART_FRAC_W_DEF = 3;
  localparam int unsigned UART_OVS_W_DEF  = 4;

  typedef logic [UART_BAUD_W_DEF-1:0] baud_val_t;

endpackage

// File: rtl/uart_baud_frac.sv
// Fractional-baud carry accumulator and stretch flag. A carry out of the accumulator
// arms the stretch flag, which adds one cycle to the current oversample period.
module uart_baud_frac
  import uart_pkg::*;
#(
  parameter int unsigned FRAC_W = UART_FRAC_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              step_i,
  input  logic              clear_i,
  input  logic              drop_stretch_i,
  input  logic [FRAC_W-1:0] fraction_i,
  output logic              stretch_req_o,
  output logic              carry_o,
  output logic [FRAC_W-1:0] acc_o
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              stretch_q, stretch_d;
  logic [FRAC_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, fraction_i};

  always_comb begin
    acc_d     = acc_q;
    stretch_d = stretch_q;
    if (clear_i) begin
      acc_d     = '0;
      stretch_d = 1'b0;
    end else if (drop_stretch_i) begin
      stretch_d = 1'b0;
    end else if (step_i) begin
      // A pending stretch consumes this step; the fraction was already added.
      if (stretch_q) begin
        stretch_d = 1'b0;
      end else begin
        acc_d     = sum[FRAC_W-1:0];
        stretch_d = sum[FRAC_W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      stretch_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      stretch_q <= stretch_d;
    end
  end

  assign stretch_req_o = stretch_q;
  assign carry_o       = sum[FRAC_W];
  assign acc_o         = acc_q;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: oversample tick, bit-rate tick and oversample phase, with fractional
// divisor support. Optional UART_BAUD_RX_RESYNC_EN adds RX_RESYNC for receiver bit-centring.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_W = UART_BAUD_W_DEF,
  parameter int unsigned FRAC_W = UART_FRAC_W_DEF,
  parameter int unsigned OVS_W  = UART_OVS_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              EN,
  input  logic [BAUD_W-1:0] BAUD_VAL,
  input  logic [FRAC_W-1:0] BAUD_VAL_FRACTION,
  input  logic              BAUD_LOAD,
`ifdef UART_BAUD_RX_RESYNC_EN
  input  logic              RX_RESYNC,
`endif
  output logic              BAUD_TICK,
  output logic              XMIT_TICK,
  output logic [OVS_W-1:0]  OVS_PHASE
);

  localparam logic [OVS_W-1:0] OvsLast = '1;
  localparam logic [OVS_W-1:0] OvsMid  = {1'b1, {(OVS_W-1){1'b0}}};

  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic [OVS_W-1:0]  phase_q, phase_d;
  logic              cnt_zero;
  logic              step;
  logic              stretch_req;
  logic              carry;
  logic [FRAC_W-1:0] acc;
  logic              resync;

`ifdef UART_BAUD_RX_RESYNC_EN
  assign resync = RX_RESYNC & ~BAUD_LOAD;
`else
  assign resync = 1'b0;
`endif

  assign cnt_zero = (cnt_q == '0);
  assign step     = EN & cnt_zero & ~BAUD_LOAD & ~resync;

  uart_baud_frac #(
    .FRAC_W(FRAC_W)
  ) u_frac (
    .clk_i         (CLK),
    .rst_ni        (RESET_N),
    .step_i        (step),
    .clear_i       (BAUD_LOAD),
    .drop_stretch_i(resync),
    .fraction_i    (BAUD_VAL_FRACTION),
    .stretch_req_o (stretch_req),
    .carry_o       (carry),
    .acc_o         (acc)
  );

  always_comb begin
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    phase_d = phase_q;
    if (BAUD_LOAD) begin
      cnt_d   = BAUD_VAL;
      phase_d = '0;
    end else if (resync) begin
      // Half a bit of oversample ticks remain until the next bit-rate tick.
      cnt_d   = BAUD_VAL;
      phase_d = OvsMid;
    end else if (EN) begin
      if (tick_q) begin
        phase_d = phase_q + OVS_W'(1);
      end
      if (!cnt_zero) begin
        cnt_d = cnt_q - BAUD_W'(1);
      end else if (stretch_req || !carry) begin
        tick_d = 1'b1;
        cnt_d  = BAUD_VAL;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
    end
  end

  assign BAUD_TICK = tick_q;
  assign XMIT_TICK = tick_q & (phase_q == OvsLast);
  assign OVS_PHASE = phase_q;

  // The accumulator value is only observed inside the fraction block.
  logic unused_acc;
  assign unused_acc = ^acc;

endmodule
